uart_send_32bit_word: RTL



---
 rtl/uart_send_32bit_word.sv | 125 ++++++++++++
 1 files changed

// File: rtl/uart_send_32bit_word.sv
// 8N1 UART transmitter sending a 32-bit word as four LSB-first bytes.
// Byte 0 is data_in[7:0]; tx is registered and idles high.
module uart_send_32bit_word #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] data_in,
  output logic        ready,
  output logic        done,
  output logic        tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [31:0]   shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic          bit_end;
  logic [7:0]    cur_byte;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    bit_end = (cnt_q == CNT_LAST);
    cnt_d   = bit_end ? '0 : cnt_q + CW'(1);

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          shreg_d = data_in;
          byte_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            if (byte_q == 2'd3) begin
              byte_d  = '0;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              byte_d  = byte_q + 2'd1;
              shreg_d = {8'h00, shreg_q[31:8]};
              state_d = START;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // tx follows the next state so the line changes exactly on bit edges
    cur_byte = shreg_d[7:0];
    unique case (1'b1)
      (state_d == START): tx_d = 1'b0;
      (state_d == DATA):  tx_d = cur_byte[bit_d];
      default:            tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = done_q;
  assign tx    = tx_q;

endmodule
